// File: rtl/imem_access_arbiter.sv
// rtl/imem_access_arbiter.sv - instruction memory arbiter: fetch reads vs loader byte-beat writes
// Optional round-robin fairness between loader and fetch: define IMEM_ARB_RR_EN.
module imem_access_arbiter #(
    parameter int MEM_BYTES = 128,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_valid,
    output logic [31:0]       f_instr,
    input  logic              l_valid,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [31:0]       l_data,
    output logic              l_ready,
    output logic              l_err,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [7:0]        mem_wdata,
    output logic              busy
);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t            state, state_nx;
    logic [1:0]        beat, beat_nx, beat_inc;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic [31:0]       data_q, data_nx;
    logic              f_valid_nx;
    logic [31:0]       f_instr_nx;
    logic              l_err_nx;
    logic              mem_we_nx;
    logic [ADDR_W-1:0] mem_waddr_nx;
    logic [7:0]        mem_wdata_nx;
    logic              rr_cond;
    logic              loader_wins;
    logic              addr_ok;

`ifdef IMEM_ARB_RR_EN
    logic last_loader, last_loader_nx;

    assign rr_cond = f_req && last_loader;

    always_comb begin
        last_loader_nx = last_loader;
        if (l_ready)
            last_loader_nx = 1'b1;
        else if (f_gnt)
            last_loader_nx = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_loader <= 1'b0;
        else
            last_loader <= last_loader_nx;
    end
`else
    assign rr_cond = 1'b0;
`endif

    assign addr_ok     = (l_addr[1:0] == 2'b00) && (l_addr <= ADDR_W'(MEM_BYTES - 4));
    assign loader_wins = l_valid && !rr_cond;
    assign l_ready     = (state == IDLE) && loader_wins;
    assign f_gnt       = (state == IDLE) && f_req && !loader_wins;
    assign mem_raddr   = f_addr;
    assign busy        = (state == WRITE);
    assign beat_inc    = beat + 2'd1;

    // The byte bus is registered and leads the beat counter by one edge, so
    // mem_we lines up exactly with the four WRITE cycles.
    always_comb begin
        state_nx     = state;
        beat_nx      = beat;
        addr_nx      = addr_q;
        data_nx      = data_q;
        f_valid_nx   = f_gnt;
        f_instr_nx   = f_gnt ? mem_rdata : f_instr;
        l_err_nx     = 1'b0;
        mem_we_nx    = 1'b0;
        mem_waddr_nx = mem_waddr;
        mem_wdata_nx = mem_wdata;
        case (state)
            IDLE: begin
                if (l_ready) begin
                    if (addr_ok) begin
                        state_nx     = WRITE;
                        beat_nx      = 2'd0;
                        addr_nx      = l_addr;
                        data_nx      = l_data;
                        mem_we_nx    = 1'b1;
                        mem_waddr_nx = l_addr;
                        mem_wdata_nx = l_data[7:0];
                    end else begin
                        l_err_nx = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (beat == 2'd3) begin
                    state_nx = IDLE;
                    beat_nx  = 2'd0;
                end else begin
                    beat_nx      = beat_inc;
                    mem_we_nx    = 1'b1;
                    mem_waddr_nx = addr_q + ADDR_W'(beat_inc);
                    mem_wdata_nx = data_q[8*beat_inc +: 8];
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            beat      <= 2'd0;
            addr_q    <= '0;
            data_q    <= '0;
            f_valid   <= 1'b0;
            f_instr   <= '0;
            l_err     <= 1'b0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_nx;
            beat      <= beat_nx;
            addr_q    <= addr_nx;
            data_q    <= data_nx;
            f_valid   <= f_valid_nx;
            f_instr   <= f_instr_nx;
            l_err     <= l_err_nx;
            mem_we    <= mem_we_nx;
            mem_waddr <= mem_waddr_nx;
            mem_wdata <= mem_wdata_nx;
        end
    end

endmodule

// File: tb/tb_imem_access_arbiter.sv
// tb/tb_imem_access_arbiter.sv - directed self-checking bench for imem_access_arbiter
module tb_imem_access_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_gnt;
    logic        f_valid;
    logic [31:0] f_instr;
    logic        l_valid;
    logic [31:0] l_addr;
    logic [31:0] l_data;
    logic        l_ready;
    logic        l_err;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [7:0]  mem_wdata;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic init_mem;

    logic [7:0] mem [0:127];
    logic [6:0] ra;

    imem_access_arbiter #(.MEM_BYTES(128), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid), .f_instr(f_instr),
        .l_valid(l_valid), .l_addr(l_addr), .l_data(l_data), .l_ready(l_ready), .l_err(l_err),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_we(mem_we),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Byte-organised little-endian memory with a combinational word read port.
    assign ra        = mem_raddr[6:0];
    assign mem_rdata = {mem[ra + 7'd3], mem[ra + 7'd2], mem[ra + 7'd1], mem[ra]};

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
            mem[4] <= 8'h93; mem[5] <= 8'h01; mem[6] <= 8'h10; mem[7] <= 8'h01;
            for (int i = 16; i < 20; i++) mem[i] <= 8'h55;
        end else if (mem_we) begin
            mem[mem_waddr[6:0]] <= mem_wdata;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL reset_f_valid: got %b expected 0", f_valid); end
        checks++; if (f_instr !== 32'h0) begin errors++; $display("FAIL reset_f_instr: got %h expected 0", f_instr); end
        checks++; if (l_err !== 1'b0) begin errors++; $display("FAIL reset_l_err: got %b expected 0", l_err); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        checks++; if (mem_waddr !== 32'h0) begin errors++; $display("FAIL reset_mem_waddr: got %h expected 0", mem_waddr); end
        checks++; if (mem_wdata !== 8'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        step;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_fetch;
        f_req = 1'b1; f_addr = 32'h04;
        #1;
        checks++; if (f_gnt !== 1'b1) begin errors++; $display("FAIL fetch_gnt: got %b expected 1", f_gnt); end
        checks++; if (mem_raddr !== 32'h04) begin errors++; $display("FAIL fetch_raddr: got %h expected 04", mem_raddr); end
        step;
        f_req = 1'b0;
        #1;
        checks++; if (f_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid: got %b expected 1", f_valid); end
        checks++; if (f_instr !== 32'h01100193) begin errors++; $display("FAIL fetch_instr: got %h expected 01100193", f_instr); end
        step;
        checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL fetch_valid_drop: got %b expected 0", f_valid); end
    endtask

    task automatic test_loader_word;
        logic [31:0] w;
        w = 32'h0031_8213;
        l_valid = 1'b1; l_addr = 32'h08; l_data = w;
        #1;
        checks++; if (l_ready !== 1'b1) begin errors++; $display("FAIL load_ready: got %b expected 1", l_ready); end
        step;
        l_valid = 1'b0;
        #1;
        for (int b = 0; b < 4; b++) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy beat %0d: got %b expected 1", b, busy); end
            checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL load_we beat %0d: got %b expected 1", b, mem_we); end
            checks++; if (mem_waddr !== 32'h08 + 32'(b)) begin errors++; $display("FAIL load_waddr beat %0d: got %h expected %h", b, mem_waddr, 32'h08 + 32'(b)); end
            checks++; if (mem_wdata !== w[8*b +: 8]) begin errors++; $display("FAIL load_wdata beat %0d: got %h expected %h", b, mem_wdata, w[8*b +: 8]); end
            step;
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL load_busy_end: got %b expected 0", busy); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL load_we_end: got %b expected 0", mem_we); end
        f_req = 1'b1; f_addr = 32'h08;
        #1;
        checks++; if (f_gnt !== 1'b1) begin errors++; $display("FAIL load_refetch_gnt: got %b expected 1", f_gnt); end
        step;
        f_req = 1'b0;
        #1;
        checks++; if (f_instr !== 32'h00318213) begin errors++; $display("FAIL load_refetch_instr: got %h expected 00318213", f_instr); end
    endtask

    task automatic test_illegal;
        logic [31:0] bad [2];
        bad[0] = 32'h0A;
        bad[1] = 32'h7E;
        for (int k = 0; k < 2; k++) begin
            l_valid = 1'b1; l_addr = bad[k]; l_data = 32'hDEADBEEF;
            #1;
            checks++; if (l_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready %h: got %b expected 1", bad[k], l_ready); end
            step;
            l_valid = 1'b0;
            #1;
            checks++; if (l_err !== 1'b1) begin errors++; $display("FAIL illegal_err %h: got %b expected 1", bad[k], l_err); end
            checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL illegal_we %h: got %b expected 0", bad[k], mem_we); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL illegal_busy %h: got %b expected 0", bad[k], busy); end
            step;
            checks++; if (l_err !== 1'b0) begin errors++; $display("FAIL illegal_err_pulse %h: got %b expected 0", bad[k], l_err); end
            checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL illegal_we_after %h: got %b expected 0", bad[k], mem_we); end
        end
        // 0x7C is the last legal word address
        l_valid = 1'b1; l_addr = 32'h7C; l_data = 32'h12345678;
        #1;
        checks++; if (l_ready !== 1'b1) begin errors++; $display("FAIL edge_ready: got %b expected 1", l_ready); end
        step;
        l_valid = 1'b0;
        #1;
        checks++; if (l_err !== 1'b0) begin errors++; $display("FAIL edge_err: got %b expected 0", l_err); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL edge_busy: got %b expected 1", busy); end
        checks++; if (mem_waddr !== 32'h7C) begin errors++; $display("FAIL edge_waddr: got %h expected 7c", mem_waddr); end
        repeat (4) step;
    endtask

    task automatic test_contention;
        logic [7:0] seq;
        int n, words;
        logic done, both;
        logic [7:0] exp_seq;
        int exp_n;
`ifdef IMEM_ARB_RR_EN
        exp_seq = 8'h15; exp_n = 6;
`else
        exp_seq = 8'h07; exp_n = 4;
`endif
        rst = 1'b1;
        step;
        rst = 1'b0;
        seq = 8'h00; n = 0; words = 0; done = 1'b0; both = 1'b0;
        f_req = 1'b1; f_addr = 32'h0;
        l_valid = 1'b1; l_addr = 32'h20; l_data = 32'h11110000;
        for (int c = 0; c < 60 && !done; c++) begin
            #1;
            if (l_ready && f_gnt) both = 1'b1;
            if (l_ready) begin
                if (n < 8) seq[n] = 1'b1;
                n++; words++;
            end else if (f_gnt) begin
                if (n < 8) seq[n] = 1'b0;
                n++;
                if (words == 3) done = 1'b1;
            end
            step;
            if (words == 3) l_valid = 1'b0;
            else begin
                l_addr = 32'h20 + 32'(4 * words);
                l_data = 32'h11110000 + 32'(words);
            end
        end
        f_req = 1'b0; l_valid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL contention_timeout: got done=%b expected 1", done); end
        checks++; if (both !== 1'b0) begin errors++; $display("FAIL contention_double_grant: got %b expected 0", both); end
        checks++; if (n !== exp_n) begin errors++; $display("FAIL contention_count: got %0d expected %0d", n, exp_n); end
        checks++; if (seq !== exp_seq) begin errors++; $display("FAIL contention_order: got %h expected %h", seq, exp_seq); end
        step;
    endtask

    task automatic test_reset_mid_write;
        l_valid = 1'b1; l_addr = 32'h10; l_data = 32'hAABBCCDD;
        #1;
        checks++; if (l_ready !== 1'b1) begin errors++; $display("FAIL rmw_ready: got %b expected 1", l_ready); end
        step;
        l_valid = 1'b0;
        step;
        step;
        checks++; if (mem_waddr !== 32'h12 || mem_we !== 1'b1) begin errors++; $display("FAIL rmw_beat2: got we=%b addr=%h expected we=1 addr=12", mem_we, mem_waddr); end
        rst = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rmw_we_async: got %b expected 0", mem_we); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmw_busy_async: got %b expected 0", busy); end
        step;
        rst = 1'b0;
        #1;
        checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL rmw_f_valid: got %b expected 0", f_valid); end
        checks++; if (l_err !== 1'b0) begin errors++; $display("FAIL rmw_l_err: got %b expected 0", l_err); end
        checks++; if ({mem[19], mem[18], mem[17], mem[16]} !== 32'h5555CCDD) begin errors++; $display("FAIL rmw_bytes: got %h expected 5555ccdd", {mem[19], mem[18], mem[17], mem[16]}); end
        f_req = 1'b1; f_addr = 32'h10;
        #1;
        checks++; if (f_gnt !== 1'b1) begin errors++; $display("FAIL rmw_idle_gnt: got %b expected 1", f_gnt); end
        step;
        f_req = 1'b0;
        #1;
        checks++; if (f_instr !== 32'h5555CCDD) begin errors++; $display("FAIL rmw_fetch: got %h expected 5555ccdd", f_instr); end
    endtask

    task automatic test_stalled_fetch;
        l_valid = 1'b1; l_addr = 32'h14; l_data = 32'hCAFEF00D;
        #1;
        step;
        l_valid = 1'b0;
        f_req = 1'b1; f_addr = 32'h14;
        #1;
        for (int b = 0; b < 4; b++) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy %0d: got %b expected 1", b, busy); end
            checks++; if (f_gnt !== 1'b0) begin errors++; $display("FAIL stall_gnt %0d: got %b expected 0", b, f_gnt); end
            step;
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_busy_end: got %b expected 0", busy); end
        checks++; if (f_gnt !== 1'b1) begin errors++; $display("FAIL stall_first_idle_gnt: got %b expected 1", f_gnt); end
        step;
        f_req = 1'b0;
        #1;
        checks++; if (f_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b expected 1", f_valid); end
        checks++; if (f_instr !== 32'hCAFEF00D) begin errors++; $display("FAIL stall_instr: got %h expected cafef00d", f_instr); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; init_mem = 1'b1;
        f_req = 1'b0; f_addr = 32'h0;
        l_valid = 1'b0; l_addr = 32'h0; l_data = 32'h0;
        @(posedge clk);
        #1;
        init_mem = 1'b0;
        test_reset;
        test_fetch;
        test_loader_word;
        test_illegal;
        test_contention;
        test_reset_mid_write;
        test_stalled_fetch;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
